// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: in-order pipeline writeback versus
// buffered multiply/divide results, with a starvation-bounded forced drain.
module wb_port_arbiter #(
  parameter int DATA_W     = 32,
  parameter int REG_W      = 5,
  parameter int MD_DEPTH   = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [1:0]                  wb_ctl,
  input  logic [DATA_W-1:0]           wb_alu,
  input  logic [DATA_W-1:0]           wb_rdata,
  input  logic [REG_W-1:0]            wb_dest,
  input  logic                        md_valid,
  input  logic [DATA_W-1:0]           md_data,
  input  logic [REG_W-1:0]            md_dest,
  output logic                        md_ready,
  output logic                        pipe_stall,
  output logic                        rf_we,
  output logic [REG_W-1:0]            rf_waddr,
  output logic [DATA_W-1:0]           rf_wdata,
  output logic [$clog2(MD_DEPTH):0]   md_count
);

  localparam int PW = $clog2(MD_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [DATA_W-1:0] fifo_data [MD_DEPTH];
  logic [REG_W-1:0]  fifo_dest [MD_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [SW-1:0]     starve;

  logic              md_any;
  logic              force_md;
  logic              grant_md;
  logic              grant_pipe;
  logic              push;
  logic [DATA_W-1:0] pipe_data;
  logic [REG_W-1:0]  head_dest;
  logic [DATA_W-1:0] head_data;

  assign md_any     = md_count != '0;
  assign md_ready   = md_count != CW'(MD_DEPTH);
  assign force_md   = md_any && (starve == SW'(STARVE_MAX));
  assign pipe_stall = force_md;
  assign grant_pipe = wb_ctl[1] && !force_md;
  assign grant_md   = force_md || (!wb_ctl[1] && md_any);
  assign push       = md_valid && md_ready;
  assign pipe_data  = wb_ctl[0] ? wb_rdata : wb_alu;
  assign head_dest  = fifo_dest[rd_ptr];
  assign head_data  = fifo_data[rd_ptr];

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= md_data;
      fifo_dest[wr_ptr] <= md_dest;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      md_count <= '0;
      starve   <= '0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (grant_md)
        rd_ptr <= rd_ptr + PW'(1);

      case ({push, grant_md})
        2'b10:   md_count <= md_count + CW'(1);
        2'b01:   md_count <= md_count - CW'(1);
        default: md_count <= md_count;
      endcase

      if (grant_md || !md_any)
        starve <= '0;
      else if (grant_pipe && starve != SW'(STARVE_MAX))
        starve <= starve + SW'(1);

      // Register-0 grants still update address/data but never strobe.
      if (grant_md) begin
        rf_we    <= head_dest != '0;
        rf_waddr <= head_dest;
        rf_wdata <= head_data;
      end else if (grant_pipe) begin
        rf_we    <= wb_dest != '0;
        rf_waddr <= wb_dest;
        rf_wdata <= pipe_data;
      end else begin
        rf_we    <= 1'b0;
      end
    end
  end

endmodule
